// File: rtl/uart_frame_check_if.sv
// Frame/result bundle between the RX deserialiser, the frame checker and the receive FIFO.
// The master side presents received frames and reads the checked results.
interface uart_frame_check_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                  frame_vld;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic [LEN_W-1:0]      data_len;
    logic [2:0]            par_mode;
    logic                  par_bit;
    logic [1:0]            stop_bits;
    logic                  two_stop;
    logic                  err_clr;

    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_vld;
    logic                  par_err;
    logic                  stop_err;
    logic                  par_err_sticky;
    logic                  stop_err_sticky;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stop_err_cnt;
    logic [CNT_WIDTH-1:0]  frame_cnt;

    modport master (
        output frame_vld, P_DATA, data_len, par_mode, par_bit, stop_bits, two_stop, err_clr,
        input  data_out, data_vld, par_err, stop_err, par_err_sticky, stop_err_sticky,
               par_err_cnt, stop_err_cnt, frame_cnt
    );

    modport slave (
        input  frame_vld, P_DATA, data_len, par_mode, par_bit, stop_bits, two_stop, err_clr,
        output data_out, data_vld, par_err, stop_err, par_err_sticky, stop_err_sticky,
               par_err_cnt, stop_err_cnt, frame_cnt
    );
endinterface

// File: rtl/uart_frame_check.sv
// UART receive frame checker: masks each character to its active length, checks the
// parity bit and stop bit(s), and keeps sticky error flags plus saturating counters.
// Every output is registered; results appear the cycle after frame_vld.
module uart_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input logic               clk,
    input logic               rst,
    uart_frame_check_if.slave bus
);
    localparam logic [LEN_W-1:0]     FULL_LEN = LEN_W'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [LEN_W-1:0]      eff_len;
    logic [DATA_WIDTH-1:0] masked;
    logic                  par_exp;
    logic                  par_chk;
    logic                  par_err_nxt;
    logic                  stop_err_nxt;
    logic                  par_hit;
    logic                  stop_hit;
    logic [CNT_WIDTH-1:0]  frame_base;
    logic [CNT_WIDTH-1:0]  par_base;
    logic [CNT_WIDTH-1:0]  stop_base;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Out-of-range lengths (0 or wider than the datapath) mean "use the full width".
    always_comb begin
        eff_len = bus.data_len;
        if (bus.data_len == '0 || bus.data_len > FULL_LEN) begin
            eff_len = FULL_LEN;
        end
    end

    // Zero every data bit at or above the active character length.
    always_comb begin
        masked = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            masked[i] = bus.P_DATA[i] & (LEN_W'(i) < eff_len);
        end
    end

    // Expected parity per mode, then per-frame parity and framing verdicts.
    always_comb begin
        par_chk = 1'b1;
        par_exp = 1'b0;
        case (bus.par_mode)
            3'b001:  par_exp = ^masked;
            3'b010:  par_exp = ~^masked;
            3'b011:  par_exp = 1'b1;
            3'b100:  par_exp = 1'b0;
            default: par_chk = 1'b0;
        endcase
        par_err_nxt  = par_chk && (bus.par_bit != par_exp);
        stop_err_nxt = !bus.stop_bits[0] || (bus.two_stop && !bus.stop_bits[1]);
        par_hit      = bus.frame_vld && par_err_nxt;
        stop_hit     = bus.frame_vld && stop_err_nxt;
    end

    // A clear zeroes the statistics first so a coincident frame is counted on top of zero.
    always_comb begin
        frame_base = bus.err_clr ? '0 : bus.frame_cnt;
        par_base   = bus.err_clr ? '0 : bus.par_err_cnt;
        stop_base  = bus.err_clr ? '0 : bus.stop_err_cnt;
    end

    // Register per-frame results, sticky flags and saturating statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_out        <= '0;
            bus.data_vld        <= 1'b0;
            bus.par_err         <= 1'b0;
            bus.stop_err        <= 1'b0;
            bus.par_err_sticky  <= 1'b0;
            bus.stop_err_sticky <= 1'b0;
            bus.par_err_cnt     <= '0;
            bus.stop_err_cnt    <= '0;
            bus.frame_cnt       <= '0;
        end else begin
            bus.data_vld <= bus.frame_vld;
            if (bus.frame_vld) begin
                bus.data_out <= masked;
                bus.par_err  <= par_err_nxt;
                bus.stop_err <= stop_err_nxt;
            end
            bus.frame_cnt       <= bus.frame_vld ? sat_inc(frame_base) : frame_base;
            bus.par_err_cnt     <= par_hit ? sat_inc(par_base) : par_base;
            bus.stop_err_cnt    <= stop_hit ? sat_inc(stop_base) : stop_base;
            bus.par_err_sticky  <= par_hit | (bus.par_err_sticky & ~bus.err_clr);
            bus.stop_err_sticky <= stop_hit | (bus.stop_err_sticky & ~bus.err_clr);
        end
    end
endmodule

// File: tb/tb_uart_frame_check.sv
// Scoreboard bench for uart_frame_check: the stimulus side predicts each frame's
// result from the character-checking rules and queues it; a monitor pops and
// compares whenever the checker presents data_vld.
module tb_uart_frame_check;
    localparam int DW      = 8;
    localparam int LW      = 4;
    localparam int CW      = 4;
    localparam int CNT_TOP = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          par_err;
        logic          stop_err;
        logic          par_sticky;
        logic          stop_sticky;
        logic [CW-1:0] par_cnt;
        logic [CW-1:0] stop_cnt;
        logic [CW-1:0] frame_cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t score_q[$];

    int   m_par_cnt;
    int   m_stop_cnt;
    int   m_frame_cnt;
    logic m_par_sticky;
    logic m_stop_sticky;
    exp_t m_last;

    uart_frame_check_if #(.DATA_WIDTH(DW), .LEN_W(LW), .CNT_WIDTH(CW)) bus ();

    uart_frame_check #(.DATA_WIDTH(DW), .LEN_W(LW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t actualOutputs();
        exp_t a;
        a.data        = bus.data_out;
        a.par_err     = bus.par_err;
        a.stop_err    = bus.stop_err;
        a.par_sticky  = bus.par_err_sticky;
        a.stop_sticky = bus.stop_err_sticky;
        a.par_cnt     = bus.par_err_cnt;
        a.stop_cnt    = bus.stop_err_cnt;
        a.frame_cnt   = bus.frame_cnt;
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_par_cnt     = 0;
        m_stop_cnt    = 0;
        m_frame_cnt   = 0;
        m_par_sticky  = 1'b0;
        m_stop_sticky = 1'b0;
        m_last        = '0;
    endtask

    // Reference model: predicts the result of one frame from the checking rules.
    task automatic pushExpected(input logic [DW-1:0] d, input logic [LW-1:0] len, input logic [2:0] mode,
                                input logic pb, input logic [1:0] sb, input logic ts, input logic clr);
        int   l;
        int   m;
        int   ones;
        logic want;
        logic checked;
        logic pe;
        logic se;
        exp_t e;
        l       = (len == 0 || int'(len) > DW) ? DW : int'(len);
        m       = int'(d) % (1 << l);
        ones    = $countones(m);
        checked = 1'b1;
        want    = 1'b0;
        case (mode)
            3'd1:    want = (ones % 2 == 1);
            3'd2:    want = (ones % 2 == 0);
            3'd3:    want = 1'b1;
            3'd4:    want = 1'b0;
            default: checked = 1'b0;
        endcase
        pe = checked && (pb != want);
        se = (sb[0] == 1'b0) || (ts && sb[1] == 1'b0);
        if (clr) begin
            m_par_cnt     = 0;
            m_stop_cnt    = 0;
            m_frame_cnt   = 0;
            m_par_sticky  = 1'b0;
            m_stop_sticky = 1'b0;
        end
        m_frame_cnt = (m_frame_cnt < CNT_TOP) ? m_frame_cnt + 1 : CNT_TOP;
        if (pe) begin
            m_par_cnt    = (m_par_cnt < CNT_TOP) ? m_par_cnt + 1 : CNT_TOP;
            m_par_sticky = 1'b1;
        end
        if (se) begin
            m_stop_cnt    = (m_stop_cnt < CNT_TOP) ? m_stop_cnt + 1 : CNT_TOP;
            m_stop_sticky = 1'b1;
        end
        e.data        = DW'(m);
        e.par_err     = pe;
        e.stop_err    = se;
        e.par_sticky  = m_par_sticky;
        e.stop_sticky = m_stop_sticky;
        e.par_cnt     = CW'(m_par_cnt);
        e.stop_cnt    = CW'(m_stop_cnt);
        e.frame_cnt   = CW'(m_frame_cnt);
        m_last        = e;
        score_q.push_back(e);
    endtask

    // Drive one frame for the next rising edge and queue its predicted result.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic [LW-1:0] len, input logic [2:0] mode,
                                 input logic pb, input logic [1:0] sb, input logic ts, input logic clr);
        @(posedge clk);
        #1;
        bus.frame_vld = 1'b1;
        bus.P_DATA    = d;
        bus.data_len  = len;
        bus.par_mode  = mode;
        bus.par_bit   = pb;
        bus.stop_bits = sb;
        bus.two_stop  = ts;
        bus.err_clr   = clr;
        pushExpected(d, len, mode, pb, sb, ts, clr);
    endtask

    task automatic idleCycles(input int n);
        @(posedge clk);
        #1;
        bus.frame_vld = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Monitor: every data_vld pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (bus.data_vld) begin
            if (score_q.size() == 0) begin
                checkOutput("unexpected_data_vld", 32'd1, 32'd0);
            end else begin
                checkOutput("frame_result", 32'(actualOutputs()), 32'(score_q.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_cnt;
        checks   = 0;
        failures = 0;
        modelReset();
        rst           = 1'b0;
        bus.frame_vld = 1'b0;
        bus.P_DATA    = '0;
        bus.data_len  = '0;
        bus.par_mode  = '0;
        bus.par_bit   = 1'b0;
        bus.stop_bits = '0;
        bus.two_stop  = 1'b0;
        bus.err_clr   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", 32'({actualOutputs(), bus.data_vld}), 32'd0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("idle_outputs", 32'({actualOutputs(), bus.data_vld}), 32'd0);

        $display("[TB] directed parity and stop checks");
        applyStimulus(8'h5A, 4'd8, 3'd1, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(8'h5A, 4'd8, 3'd1, 1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(8'hFF, 4'd5, 3'd2, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(8'hFF, 4'd5, 3'd3, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(8'hFF, 4'd5, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(8'hC3, 4'd0, 3'd4, 1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(8'h3C, 4'd8, 3'd0, 1'b0, 2'b01, 1'b1, 1'b0);
        applyStimulus(8'h3C, 4'd8, 3'd0, 1'b0, 2'b11, 1'b1, 1'b0);
        applyStimulus(8'h3C, 4'd8, 3'd0, 1'b0, 2'b10, 1'b0, 1'b0);
        applyStimulus(8'hA7, 4'd12, 3'd6, 1'b1, 2'b00, 1'b1, 1'b0);
        idleCycles(3);

        $display("[TB] clear without a frame");
        @(posedge clk);
        #1;
        bus.err_clr = 1'b1;
        m_par_cnt     = 0;
        m_stop_cnt    = 0;
        m_frame_cnt   = 0;
        m_par_sticky  = 1'b0;
        m_stop_sticky = 1'b0;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        checkOutput("clear_keeps_result", 32'({bus.data_out, bus.par_err, bus.stop_err}),
                    32'({m_last.data, m_last.par_err, m_last.stop_err}));
        checkOutput("clear_zeroes_stats",
                    32'({bus.par_err_sticky, bus.stop_err_sticky, bus.par_err_cnt, bus.stop_err_cnt, bus.frame_cnt}),
                    32'd0);

        $display("[TB] counter saturation");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h01, 4'd8, 3'd1, 1'b0, 2'b01, 1'b0, 1'b0);
        end
        applyStimulus(8'h01, 4'd8, 3'd1, 1'b0, 2'b01, 1'b0, 1'b1);
        idleCycles(3);

        $display("[TB] randomized frames");
        for (int i = 0; i < 250; i++) begin
            applyStimulus(DW'($urandom), LW'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                          1'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) begin
                idleCycles($urandom_range(0, 2));
            end
        end
        idleCycles(3);

        $display("[TB] reset during a burst");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(DW'($urandom), 4'd8, 3'd1, 1'($urandom), 2'($urandom), 1'b1, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.frame_vld = 1'b0;
        rst = 1'b0;
        score_q.delete();
        modelReset();
        #1;
        checkOutput("async_reset_outputs", 32'({actualOutputs(), bus.data_vld}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(8'h96, 4'd8, 3'd2, 1'b0, 2'b11, 1'b1, 1'b0);
        idleCycles(3);

        wait_cnt = 0;
        while (score_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        checkOutput("queue_drained", 32'(score_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
